// File: rtl/instr_mem_loader.sv
// -----------------------------------------------------------------------------
// instr_mem_loader
//
// Fills the byte-wide instruction memory before the pipeline starts fetching.
// 32-bit words arrive on a valid/ready stream. Each word is written as four
// little-endian bytes at consecutive byte addresses, so IM[pc] holds
// instruction[7:0] and IM[pc+3] holds instruction[31:24]. The CPU is held
// stalled until a session completes.
//
// Ports
//   clk           system clock, all logic on posedge
//   reset         synchronous, active-high reset
//   start         one-cycle pulse, begins a session at byte address 0
//   word_valid    word_data / word_last are valid
//   word_data     instruction word to store
//   word_last     current word is the final word of the session
//   word_ready    loader accepts a word this cycle
//   mem_we        byte write enable to instruction memory
//   mem_addr      byte address of the write
//   mem_wdata     byte to write
//   busy          session in progress
//   done          session completed (held)
//   overflow      a word would have exceeded DEPTH (held)
//   cpu_stall     pipeline must not fetch
//   words_loaded  words fully written this session
//
// State table
//   state       | meaning
//   S_IDLE      | after reset, waiting for start
//   S_WAIT_WORD | word_ready=1, waiting for a word
//   S_WRITE     | emitting byte beats 1..3, then the word-complete cycle
//   S_DONE      | session finished, CPU released
//   S_ERR       | overflow detected, nothing written for the offending word
// -----------------------------------------------------------------------------
module instr_mem_loader #(
   parameter int unsigned DEPTH = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        word_valid,
   input  logic [31:0] word_data,
   input  logic        word_last,
   output logic        word_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        busy,
   output logic        done,
   output logic        overflow,
   output logic        cpu_stall,
   output logic [15:0] words_loaded
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_WORD,
      S_WRITE,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [31:0] DEPTH_W = 32'(DEPTH);

   state_t      state_q, state_d;
   logic [31:0] base_q, base_d;
   logic [1:0]  beat_q, beat_d;
   logic [31:0] word_q, word_d;
   logic        last_q, last_d;

   logic        word_ready_q, word_ready_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [7:0]  mem_wdata_q, mem_wdata_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        overflow_q, overflow_d;
   logic        cpu_stall_q, cpu_stall_d;
   logic [15:0] words_loaded_q, words_loaded_d;

   logic [31:0] base_plus4;
   logic [7:0]  beat_byte;

   assign base_plus4 = base_q + 32'd4;

   always_comb begin
      beat_byte = word_q[7:0];
      case (beat_q)
         2'd1:    beat_byte = word_q[15:8];
         2'd2:    beat_byte = word_q[23:16];
         2'd3:    beat_byte = word_q[31:24];
         default: beat_byte = word_q[7:0];
      endcase
   end

   // beat_q holds the index of the next byte to emit. Beat 0 is registered
   // on the accepting edge, so WRITE sees beat_q = 1,2,3 and then wraps to 0,
   // which marks the word-complete cycle.
   always_comb begin
      state_d        = state_q;
      base_d         = base_q;
      beat_d         = beat_q;
      word_d         = word_q;
      last_d         = last_q;
      word_ready_d   = word_ready_q;
      mem_we_d       = 1'b0;
      mem_addr_d     = mem_addr_q;
      mem_wdata_d    = mem_wdata_q;
      busy_d         = busy_q;
      done_d         = done_q;
      overflow_d     = overflow_q;
      cpu_stall_d    = cpu_stall_q;
      words_loaded_d = words_loaded_q;

      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_d        = S_WAIT_WORD;
               base_d         = 32'd0;
               words_loaded_d = 16'd0;
               done_d         = 1'b0;
               overflow_d     = 1'b0;
               word_ready_d   = 1'b1;
               busy_d         = 1'b1;
               cpu_stall_d    = 1'b1;
            end
         end

         S_WAIT_WORD: begin
            if (word_valid && word_ready_q) begin
               word_ready_d = 1'b0;
               // word_last is deliberately ignored on an overflowing word
               if (base_plus4 > DEPTH_W) begin
                  overflow_d = 1'b1;
                  busy_d     = 1'b0;
                  state_d    = S_ERR;
               end else begin
                  word_d      = word_data;
                  last_d      = word_last;
                  mem_we_d    = 1'b1;
                  mem_addr_d  = base_q;
                  mem_wdata_d = word_data[7:0];
                  beat_d      = 2'd1;
                  state_d     = S_WRITE;
               end
            end
         end

         S_WRITE: begin
            if (beat_q != 2'd0) begin
               mem_we_d    = 1'b1;
               mem_addr_d  = base_q + {30'd0, beat_q};
               mem_wdata_d = beat_byte;
               beat_d      = beat_q + 2'd1;
            end else begin
               base_d         = base_plus4;
               words_loaded_d = words_loaded_q + 16'd1;
               if (last_q) begin
                  state_d     = S_DONE;
                  done_d      = 1'b1;
                  cpu_stall_d = 1'b0;
                  busy_d      = 1'b0;
               end else begin
                  state_d      = S_WAIT_WORD;
                  word_ready_d = 1'b1;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         base_q         <= 32'd0;
         beat_q         <= 2'd0;
         word_q         <= 32'd0;
         last_q         <= 1'b0;
         word_ready_q   <= 1'b0;
         mem_we_q       <= 1'b0;
         mem_addr_q     <= 32'd0;
         mem_wdata_q    <= 8'd0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         overflow_q     <= 1'b0;
         cpu_stall_q    <= 1'b1;
         words_loaded_q <= 16'd0;
      end else begin
         state_q        <= state_d;
         base_q         <= base_d;
         beat_q         <= beat_d;
         word_q         <= word_d;
         last_q         <= last_d;
         word_ready_q   <= word_ready_d;
         mem_we_q       <= mem_we_d;
         mem_addr_q     <= mem_addr_d;
         mem_wdata_q    <= mem_wdata_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         overflow_q     <= overflow_d;
         cpu_stall_q    <= cpu_stall_d;
         words_loaded_q <= words_loaded_d;
      end
   end

   assign word_ready   = word_ready_q;
   assign mem_we       = mem_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign overflow     = overflow_q;
   assign cpu_stall    = cpu_stall_q;
   assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// -----------------------------------------------------------------------------
// Bench for instr_mem_loader. Two instances share clock, reset and the word
// stream: u_dut64 (DEPTH=64) and u_dut8 (DEPTH=8). Only the instance selected
// by sel is started, so the other never raises word_ready. Expected byte
// writes are pushed when a word is accepted and popped as mem_we appears.
// -----------------------------------------------------------------------------
module tb_instr_mem_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        start64, start8;
   logic        word_valid, word_last;
   logic [31:0] word_data;

   logic        rdy64, we64, busy64, done64, ovf64, stall64;
   logic [31:0] addr64;
   logic [7:0]  wd64;
   logic [15:0] wl64;

   logic        rdy8, we8, busy8, done8, ovf8, stall8;
   logic [31:0] addr8;
   logic [7:0]  wd8;
   logic [15:0] wl8;

   instr_mem_loader #(.DEPTH(64)) u_dut64 (
      .clk          (clk),
      .reset        (reset),
      .start        (start64),
      .word_valid   (word_valid),
      .word_data    (word_data),
      .word_last    (word_last),
      .word_ready   (rdy64),
      .mem_we       (we64),
      .mem_addr     (addr64),
      .mem_wdata    (wd64),
      .busy         (busy64),
      .done         (done64),
      .overflow     (ovf64),
      .cpu_stall    (stall64),
      .words_loaded (wl64)
   );

   instr_mem_loader #(.DEPTH(8)) u_dut8 (
      .clk          (clk),
      .reset        (reset),
      .start        (start8),
      .word_valid   (word_valid),
      .word_data    (word_data),
      .word_last    (word_last),
      .word_ready   (rdy8),
      .mem_we       (we8),
      .mem_addr     (addr8),
      .mem_wdata    (wd8),
      .busy         (busy8),
      .done         (done8),
      .overflow     (ovf8),
      .cpu_stall    (stall8),
      .words_loaded (wl8)
   );

   typedef struct packed {
      logic [31:0] a;
      logic [7:0]  d;
   } wr_t;

   wr_t         q64[$];
   wr_t         q8[$];
   int unsigned exp_base [2];
   int unsigned depth_of [2] = '{64, 8};
   bit          sel = 1'b0;

   int n_vec  = 0;
   int n_miss = 0;
   int cyc    = 0;
   int last_wr_cyc64 = 0;
   int last_wr_cyc8  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic cur_ready();
      return sel ? rdy8 : rdy64;
   endfunction

   // scoreboard consumers
   always @(negedge clk) begin
      wr_t e;
      if (we64 === 1'b1) begin
         chk("wr64_expected", 32'(q64.size() > 0), 1);
         if (q64.size() > 0) begin
            e = q64.pop_front();
            chk("wr64_addr", addr64, e.a);
            chk("wr64_data", {24'd0, wd64}, {24'd0, e.d});
            last_wr_cyc64 = cyc;
         end
      end
      if (we8 === 1'b1) begin
         chk("wr8_expected", 32'(q8.size() > 0), 1);
         if (q8.size() > 0) begin
            e = q8.pop_front();
            chk("wr8_addr", addr8, e.a);
            chk("wr8_data", {24'd0, wd8}, {24'd0, e.d});
            last_wr_cyc8 = cyc;
         end
      end
   end

   task automatic chk_reset(input bit s);
      chk("rst_ready",  s ? rdy8   : rdy64,   0);
      chk("rst_we",     s ? we8    : we64,    0);
      chk("rst_addr",   s ? addr8  : addr64,  0);
      chk("rst_wdata",  s ? wd8    : wd64,    0);
      chk("rst_busy",   s ? busy8  : busy64,  0);
      chk("rst_done",   s ? done8  : done64,  0);
      chk("rst_ovf",    s ? ovf8   : ovf64,   0);
      chk("rst_stall",  s ? stall8 : stall64, 1);
      chk("rst_wl",     s ? wl8    : wl64,    0);
   endtask

   task automatic do_start(input bit s);
      sel = s;
      @(negedge clk);
      if (s) start8 = 1'b1; else start64 = 1'b1;
      @(posedge clk); #1;
      start8  = 1'b0;
      start64 = 1'b0;
      exp_base[s] = 0;
      chk("start_ready", s ? rdy8  : rdy64,  1);
      chk("start_busy",  s ? busy8 : busy64, 1);
      chk("start_done",  s ? done8 : done64, 0);
      chk("start_ovf",   s ? ovf8  : ovf64,  0);
      chk("start_wl",    s ? wl8   : wl64,   0);
      chk("start_stall", s ? stall8 : stall64, 1);
   endtask

   // Drives a word and returns just after the accepting edge with word_valid
   // still high; the caller decides whether to drop valid or send another.
   task automatic send_word(input logic [31:0] d, input logic l, output int acc_cyc);
      int  n;
      wr_t e;
      n = 0;
      word_data  = d;
      word_last  = l;
      word_valid = 1'b1;
      while (cur_ready() !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (cur_ready() !== 1'b1) begin
         chk("accept_timeout", 32'(cur_ready()), 1);
         word_valid = 1'b0;
         acc_cyc = -1;
         return;
      end
      @(posedge clk); #1;
      acc_cyc = cyc;
      if (exp_base[sel] + 4 <= depth_of[sel]) begin
         for (int k = 0; k < 4; k++) begin
            e.a = exp_base[sel] + 32'(k);
            e.d = d[8*k +: 8];
            if (sel) q8.push_back(e); else q64.push_back(e);
         end
         exp_base[sel] += 4;
      end
   endtask

   task automatic wait_done(input bit s, output int dc);
      int n;
      n = 0;
      dc = -1;
      while (n < 50) begin
         @(negedge clk);
         if ((s ? done8 : done64) === 1'b1) begin
            dc = cyc;
            break;
         end
         n++;
      end
      chk("done_seen", 32'(dc >= 0), 1);
   endtask

   task automatic wait_ready(input bit s);
      int n;
      n = 0;
      while ((s ? rdy8 : rdy64) !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("ready_return", s ? rdy8 : rdy64, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int a1, a2, dc;
      logic [31:0] gap_words [3];
      gap_words[0] = 32'hA1B2C3D4;
      gap_words[1] = 32'h01020304;
      gap_words[2] = 32'hF0E1D2C3;

      reset      = 1'b1;
      start64    = 1'b1;   // coincident with reset, must be ignored
      start8     = 1'b0;
      word_valid = 1'b0;
      word_last  = 1'b0;
      word_data  = 32'd0;
      exp_base[0] = 0;
      exp_base[1] = 0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset(0);
      chk_reset(1);
      reset   = 1'b0;
      start64 = 1'b0;
      @(posedge clk); #1;
      chk("start_during_reset_ignored", rdy64, 0);
      chk("idle_busy", busy64, 0);

      // two-word load, back to back: second word held valid through WRITE
      do_start(0);
      send_word(32'h8C010004, 1'b0, a1);
      send_word(32'h00221820, 1'b1, a2);
      word_valid = 1'b0;
      chk("word_period", 32'(a2 - a1), 5);
      wait_done(0, dc);
      chk("done_after_last_write", 32'(dc - last_wr_cyc64), 1);
      chk("two_word_stall", stall64, 0);
      chk("two_word_wl", wl64, 2);
      chk("two_word_busy", busy64, 0);
      chk("two_word_drained", q64.size(), 0);

      // restart from DONE
      do_start(0);
      send_word(32'hDEADBEEF, 1'b1, a1);
      word_valid = 1'b0;
      wait_done(0, dc);
      chk("restart_wl", wl64, 1);
      chk("restart_done", done64, 1);
      chk("restart_drained", q64.size(), 0);

      // gaps between words
      do_start(0);
      for (int i = 0; i < 3; i++) begin
         send_word(gap_words[i], (i == 2), a1);
         word_valid = 1'b0;
         word_data  = 32'hBAD0BAD0;
         if (i < 2) begin
            wait_ready(0);
            for (int g = 0; g < 3; g++) begin
               @(negedge clk);
               chk("gap_ready", rdy64, 1);
               chk("gap_no_write", we64, 0);
            end
         end
      end
      wait_done(0, dc);
      chk("gap_wl", wl64, 3);
      chk("gap_drained", q64.size(), 0);

      // overflow on the DEPTH=8 instance
      do_start(1);
      send_word(32'h13579BDF, 1'b0, a1);
      send_word(32'h2468ACE0, 1'b0, a1);
      send_word(32'h55AA55AA, 1'b1, a1);   // last flag ignored on overflow
      word_valid = 1'b0;
      chk("ovf_flag", ovf8, 1);
      chk("ovf_ready", rdy8, 0);
      chk("ovf_stall", stall8, 1);
      chk("ovf_done", done8, 0);
      chk("ovf_busy", busy8, 0);
      chk("ovf_wl", wl8, 2);
      chk("ovf_no_write", we8, 0);
      repeat (3) @(negedge clk);
      chk("ovf_held", ovf8, 1);
      chk("ovf_drained", q8.size(), 0);
      do_start(1);
      send_word(32'hCAFEF00D, 1'b1, a1);
      word_valid = 1'b0;
      wait_done(1, dc);
      chk("ovf_restart_wl", wl8, 1);
      chk("ovf_restart_drained", q8.size(), 0);

      // reset in the middle of a word: only beats 0 and 1 reach memory
      do_start(0);
      send_word(32'h11223344, 1'b1, a1);
      word_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid_pending", q64.size(), 2);
      q64.delete();
      exp_base[0] = 0;
      chk_reset(0);
      @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      chk("rst_mid_idle_ready", rdy64, 0);

      chk("final_q64_empty", q64.size(), 0);
      chk("final_q8_empty", q8.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
